// File: rtl/apb2axi_tag_directory_if.sv
// Shared types and the bus interface of the APB2AXI tag directory.
// Tag fields are 8 bits wide, enough for directories of up to 256 entries.
package apb2axi_dir_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_ALLOCATED = 2'd1,
        ST_PENDING   = 2'd2,
        ST_COMPLETE  = 2'd3
    } entry_state_e;

    typedef enum logic [1:0] {
        DIR_ST_IDLE   = 2'd0,
        DIR_ST_ISSUED = 2'd1,
        DIR_ST_DONE   = 2'd2,
        DIR_ST_ERROR  = 2'd3
    } dir_status_e;

    typedef struct packed {
        logic [7:0]  tag;
        logic        is_write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  resp;
        logic [7:0]  num_beats;
        dir_status_e state;
    } directory_entry_t;

    typedef struct packed {
        logic [7:0] tag;
        logic [1:0] resp;
        logic [7:0] num_beats;
        logic       error;
    } completion_entry_t;
endpackage

interface apb2axi_tag_directory_if
    import apb2axi_dir_pkg::*;
#(
    parameter int DIR_ENTRIES   = 16,
    parameter int TAG_WIDTH     = $clog2(DIR_ENTRIES),
    parameter int NUM_CPL_PORTS = 2
);
    logic                                  reg_dir_alloc_vld;
    directory_entry_t                      reg_dir_alloc_entry;
    logic                                  reg_dir_alloc_ready;
    logic [TAG_WIDTH-1:0]                  reg_dir_alloc_tag;
    logic                                  reg_dir_entry_consumed;
    logic [TAG_WIDTH-1:0]                  reg_dir_tag_sel;
    directory_entry_t                      reg_dir_entry;
    entry_state_e                          reg_dir_entry_state;
    logic                                  dir_mgr_pop_valid;
    directory_entry_t                      dir_mgr_pop_entry;
    logic                                  dir_mgr_pop_ready;
    logic [NUM_CPL_PORTS-1:0]              cq_dir_cpl_vld;
    completion_entry_t [NUM_CPL_PORTS-1:0] cq_dir_cpl_entry;
    logic [NUM_CPL_PORTS-1:0]              cq_dir_cpl_ready;
    logic [TAG_WIDTH:0]                    dir_occupancy;
    logic                                  dir_err_spurious_cpl;
    logic                                  dir_err_bad_consume;

    modport slave (
        input  reg_dir_alloc_vld, reg_dir_alloc_entry,
        input  reg_dir_entry_consumed, reg_dir_tag_sel,
        input  dir_mgr_pop_ready, cq_dir_cpl_vld, cq_dir_cpl_entry,
        output reg_dir_alloc_ready, reg_dir_alloc_tag,
        output reg_dir_entry, reg_dir_entry_state,
        output dir_mgr_pop_valid, dir_mgr_pop_entry,
        output cq_dir_cpl_ready, dir_occupancy,
        output dir_err_spurious_cpl, dir_err_bad_consume
    );

    modport master (
        output reg_dir_alloc_vld, reg_dir_alloc_entry,
        output reg_dir_entry_consumed, reg_dir_tag_sel,
        output dir_mgr_pop_ready, cq_dir_cpl_vld, cq_dir_cpl_entry,
        input  reg_dir_alloc_ready, reg_dir_alloc_tag,
        input  reg_dir_entry, reg_dir_entry_state,
        input  dir_mgr_pop_valid, dir_mgr_pop_entry,
        input  cq_dir_cpl_ready, dir_occupancy,
        input  dir_err_spurious_cpl, dir_err_bad_consume
    );
endinterface

// File: rtl/apb2axi_tag_directory.sv
// Tag directory tracking outstanding APB-initiated AXI transactions.
// Optional PENDING watchdog enabled by defining APB2AXI_DIR_TIMEOUT_EN.
module apb2axi_tag_directory
    import apb2axi_dir_pkg::*;
#(
    parameter int DIR_ENTRIES    = 16,
    parameter int TAG_WIDTH      = $clog2(DIR_ENTRIES),
    parameter int NUM_CPL_PORTS  = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                     pclk,
    input logic                     preset,
    apb2axi_tag_directory_if.slave  bus
);
    entry_state_e         state_q [DIR_ENTRIES];
    entry_state_e         state_d [DIR_ENTRIES];
    directory_entry_t     entry_q [DIR_ENTRIES];
    directory_entry_t     entry_d [DIR_ENTRIES];
    logic [TAG_WIDTH-1:0] fifo_q  [DIR_ENTRIES];
    logic [TAG_WIDTH-1:0] fifo_d  [DIR_ENTRIES];
    logic [TAG_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [TAG_WIDTH:0]   fifo_cnt_q, fifo_cnt_d, occ_q, occ_d;
    logic                 spur_q, spur_d, bad_q, bad_d;

    logic                 any_free, do_alloc, do_pop, cons_ok;
    logic [TAG_WIDTH-1:0] free_tag, head, ctag;
    logic [DIR_ENTRIES-1:0] cpl_hit;

    // Scanning downward leaves the lowest EMPTY index as the winner.
    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        for (int i = DIR_ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ST_EMPTY) begin
                any_free = 1'b1;
                free_tag = TAG_WIDTH'(i);
            end
        end
    end

    assign head     = fifo_q[rd_ptr_q];
    assign do_alloc = bus.reg_dir_alloc_vld && any_free;
    assign do_pop   = bus.dir_mgr_pop_valid && bus.dir_mgr_pop_ready;

    assign bus.reg_dir_alloc_ready  = any_free;
    assign bus.reg_dir_alloc_tag    = free_tag;
    assign bus.reg_dir_entry        = entry_q[bus.reg_dir_tag_sel];
    assign bus.reg_dir_entry_state  = state_q[bus.reg_dir_tag_sel];
    assign bus.dir_mgr_pop_valid    = (fifo_cnt_q != '0);
    assign bus.dir_mgr_pop_entry    = entry_q[head];
    assign bus.cq_dir_cpl_ready     = '1;
    assign bus.dir_occupancy        = occ_q;
    assign bus.dir_err_spurious_cpl = spur_q;
    assign bus.dir_err_bad_consume  = bad_q;

`ifdef APB2AXI_DIR_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q [DIR_ENTRIES];
    logic [WDW-1:0] wd_d [DIR_ENTRIES];
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        spur_d     = spur_q;
        bad_d      = bad_q;
        cpl_hit    = '0;
        ctag       = '0;
        cons_ok    = 1'b0;
        if (do_pop) begin
            state_d[head] = ST_PENDING;
            rd_ptr_d      = rd_ptr_q + 1'b1;
        end
        if (do_alloc) begin
            entry_d[free_tag]           = bus.reg_dir_alloc_entry;
            entry_d[free_tag].tag       = 8'(free_tag);
            entry_d[free_tag].resp      = '0;
            entry_d[free_tag].num_beats = '0;
            state_d[free_tag]           = ST_ALLOCATED;
            fifo_d[wr_ptr_q]            = free_tag;
            wr_ptr_d                    = wr_ptr_q + 1'b1;
        end
        fifo_cnt_d = fifo_cnt_q + (TAG_WIDTH+1)'(do_alloc)
                   - (TAG_WIDTH+1)'(do_pop);
        // Lower port index claims a tag first; duplicates fall to spurious.
        for (int p = 0; p < NUM_CPL_PORTS; p++) begin
            if (bus.cq_dir_cpl_vld[p]) begin
                ctag = bus.cq_dir_cpl_entry[p].tag[TAG_WIDTH-1:0];
                if (state_q[ctag] == ST_PENDING && !cpl_hit[ctag]) begin
                    cpl_hit[ctag]           = 1'b1;
                    state_d[ctag]           = ST_COMPLETE;
                    entry_d[ctag].resp      = bus.cq_dir_cpl_entry[p].resp;
                    entry_d[ctag].num_beats = bus.cq_dir_cpl_entry[p].num_beats;
                    entry_d[ctag].state     = bus.cq_dir_cpl_entry[p].error
                                            ? DIR_ST_ERROR : DIR_ST_DONE;
                end else begin
                    spur_d = 1'b1;
                end
            end
        end
        if (bus.reg_dir_entry_consumed) begin
            if (state_q[bus.reg_dir_tag_sel] == ST_COMPLETE) begin
                cons_ok                          = 1'b1;
                state_d[bus.reg_dir_tag_sel]     = ST_EMPTY;
                entry_d[bus.reg_dir_tag_sel]     = '0;
            end else begin
                bad_d = 1'b1;
            end
        end
        occ_d = occ_q + (TAG_WIDTH+1)'(do_alloc) - (TAG_WIDTH+1)'(cons_ok);
`ifdef APB2AXI_DIR_TIMEOUT_EN
        for (int i = 0; i < DIR_ENTRIES; i++) begin
            wd_d[i] = (state_q[i] == ST_PENDING) ? wd_q[i] + 1'b1 : '0;
            if (state_q[i] == ST_PENDING && !cpl_hit[i]
                && wd_q[i] == WDW'(TIMEOUT_CYCLES - 1)) begin
                state_d[i]       = ST_COMPLETE;
                entry_d[i].resp  = 2'b10;
                entry_d[i].state = DIR_ST_ERROR;
            end
        end
`endif
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DIR_ENTRIES; i++) begin
                state_q[i] <= ST_EMPTY;
                entry_q[i] <= '0;
                fifo_q[i]  <= '0;
`ifdef APB2AXI_DIR_TIMEOUT_EN
                wd_q[i]    <= '0;
`endif
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            occ_q      <= '0;
            spur_q     <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            fifo_q     <= fifo_d;
`ifdef APB2AXI_DIR_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            occ_q      <= occ_d;
            spur_q     <= spur_d;
            bad_q      <= bad_d;
        end
    end
endmodule
